// File: rtl/rng_pkg.sv
// Shared types and LFSR helpers for the random range generator.
package rng_pkg;

    typedef enum logic [1:0] {IDLE, GEN, HOLD} rng_state_t;

    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Galois right-shift step; narrower states ride zero-extended in 32 bits.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Galois LFSR with step enable and seed load; a zero seed falls back to SEED.
module lfsr_galois
    import rng_pkg::*;
#(
    parameter int          WIDTH = 16,
    parameter logic [31:0] SEED  = 32'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    localparam logic [31:0]      TAPS   = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] SEED_W = SEED[WIDTH-1:0];

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            // all-zero is the lock-up state of the LFSR
            state_d = (load_val == '0) ? SEED_W : load_val;
        end else if (step) begin
            state_d = WIDTH'(lfsr_next(32'(state_q), TAPS));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SEED_W;
        else      state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/random_range_generator.sv
// Uniform [0, LIMIT-1] generator: LFSR + rejection sampling with bounded-retry fallback.
// Optional RNG_FREE_RUN_EN: LFSR also steps in IDLE/HOLD (timing-dependent output).
module random_range_generator
    import rng_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          LIMIT     = 15,
    parameter logic [31:0] SEED      = 32'hACE1,
    parameter int          MAX_TRIES = 4,
    localparam int         OUT_W     = (LIMIT > 2) ? $clog2(LIMIT) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             rnd_ready,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [OUT_W-1:0] rnd_value,
    output logic             rnd_valid,
    output logic             busy
);

    localparam logic [31:0]      TAPS     = lfsr_taps(WIDTH);
    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [31:0]      LIM32    = 32'(LIMIT);
    localparam logic [31:0]      LAST32   = 32'(MAX_TRIES - 1);
    localparam logic [OUT_W:0]   LIM_W    = LIM32[OUT_W:0];
    localparam logic [OUT_W-1:0] LIM_LO   = LIM32[OUT_W-1:0];
    localparam logic [TRY_W-1:0] LAST_TRY = LAST32[TRY_W-1:0];

    rng_state_t       state_q, state_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic             valid_q, valid_d;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_state;
    logic [OUT_W-1:0] cand;

    lfsr_galois #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (lfsr_step),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    // candidate is taken from the state the LFSR moves to on this edge
    assign cand = OUT_W'(lfsr_next(32'(lfsr_state), TAPS));

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        value_d = value_q;
        valid_d = valid_q;
`ifdef RNG_FREE_RUN_EN
        lfsr_step = 1'b1;
`else
        lfsr_step = 1'b0;
`endif
        if (seed_load) begin
            state_d = IDLE;
            tries_d = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = GEN;
                        tries_d = '0;
                    end
                end
                GEN: begin
                    lfsr_step = 1'b1;
                    if ({1'b0, cand} < LIM_W) begin
                        value_d = cand;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else if (tries_q == LAST_TRY) begin
                        // LIMIT > 2**(OUT_W-1), so one subtraction lands in range
                        value_d = cand - LIM_LO;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                    end
                end
                HOLD: begin
                    if (rnd_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tries_q <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tries_q <= tries_d;
            value_q <= value_d;
            valid_q <= valid_d;
        end
    end

    assign rnd_value = value_q;
    assign rnd_valid = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_random_range_generator.sv
// Scoreboard bench: three 8-bit instances (accept, rejection, fallback) with directed vectors.
module tb_random_range_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = '0;
    logic [2:0] rdy = '0;
    logic [2:0] sl  = '0;
    logic [7:0] seed_in = '0;
    logic [3:0] val [3];
    logic [2:0] vld;
    logic [2:0] bsy;
    logic [2:0] pv = '0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int inst;
        int v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    random_range_generator #(.WIDTH(8), .LIMIT(15), .SEED(32'hFF), .MAX_TRIES(4)) dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .rnd_ready(rdy[0]), .seed_load(sl[0]),
        .seed_in(seed_in), .rnd_value(val[0]), .rnd_valid(vld[0]), .busy(bsy[0]));
    random_range_generator #(.WIDTH(8), .LIMIT(10), .SEED(32'hFF), .MAX_TRIES(4)) dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .rnd_ready(rdy[1]), .seed_load(sl[1]),
        .seed_in(seed_in), .rnd_value(val[1]), .rnd_valid(vld[1]), .busy(bsy[1]));
    random_range_generator #(.WIDTH(8), .LIMIT(10), .SEED(32'hFF), .MAX_TRIES(1)) dut2 (
        .clk(clk), .rst(rst), .req(req[2]), .rnd_ready(rdy[2]), .seed_load(sl[2]),
        .seed_in(seed_in), .rnd_value(val[2]), .rnd_valid(vld[2]), .busy(bsy[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every rising rnd_valid must match the next scoreboard entry
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && !pv[i]) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected: inst %0d got value %0d with nothing expected", i, val[i]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check($sformatf("sb_inst%0d", i), i, e.inst);
                    check($sformatf("sb_val%0d", i), 32'(val[i]), e.v);
                end
            end
            pv[i] <= vld[i];
        end
    end

    task automatic do_req(input int i, input int exp_v, input int exp_lat, input bit ack);
        int cnt;
        sb.push_back('{i, exp_v});
        @(negedge clk);
        rdy[i] = ack;
        req[i] = 1'b1;
        @(posedge clk); #1;
        req[i] = 1'b0;
        cnt = 1;
        while (!vld[i] && cnt < 20) begin
            check($sformatf("busy_gen%0d", i), 32'(bsy[i]), 1);
            @(posedge clk); #1;
            cnt++;
        end
        check($sformatf("latency%0d_v%0d", i, exp_v), cnt, exp_lat);
        if (ack) begin
            @(posedge clk); #1;
            check($sformatf("valid_drop%0d", i), 32'(vld[i]), 0);
            check($sformatf("busy_idle%0d", i), 32'(bsy[i]), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held two cycles with requests pulsed
        #2 req = 3'b111;
        @(posedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_valid%0d", i), 32'(vld[i]), 0);
            check($sformatf("rst_value%0d", i), 32'(val[i]), 0);
            check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 0);
        end
        req = '0;
        @(negedge clk) rst = 1'b1;

        // accept path, LIMIT=15
        do_req(0, 7, 2, 1);
        do_req(0, 11, 2, 1);
        do_req(0, 5, 2, 1);
        do_req(0, 2, 2, 1);

        // rejection, LIMIT=10: 11 rejected then 5
        do_req(1, 7, 2, 1);
        do_req(1, 5, 3, 1);

        // fallback, MAX_TRIES=1: 11-10
        do_req(2, 7, 2, 1);
        do_req(2, 1, 2, 1);

        // backpressure: state 0xD2 steps to 0x69 -> 9
        do_req(0, 9, 2, 0);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(vld[0]), 1);
            check("hold_value", 32'(val[0]), 9);
        end
        @(negedge clk);
        seed_in = 8'h00;
        sl[0] = 1'b1;
        @(posedge clk); #1;
        sl[0] = 1'b0;
        check("reseed_valid", 32'(vld[0]), 0);
        check("reseed_busy", 32'(bsy[0]), 0);
        check("reseed_lfsr", 32'(dut0.u_lfsr.state), 32'hFF);
        do_req(0, 7, 2, 1);

        // reset while dut1 is in GEN (it holds value 5 from before)
        @(negedge clk);
        req[1] = 1'b1;
        @(posedge clk); #1;
        req[1] = 1'b0;
        check("midgen_busy", 32'(bsy[1]), 1);
        #1 rst = 1'b0;
        #1;
        check("midgen_rst_valid", 32'(vld[1]), 0);
        check("midgen_rst_value", 32'(val[1]), 0);
        check("midgen_rst_busy", 32'(bsy[1]), 0);
        @(negedge clk) rst = 1'b1;
        do_req(1, 7, 2, 1);
        do_req(2, 7, 2, 1);
        do_req(0, 7, 2, 1);

        repeat (3) @(posedge clk);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
